// File: rtl/fpga_mem_dmaster_st_channel_arbiter_pkg.sv
// Shared constants for the debug-master stream arbiter: FSM encoding, widths,
// and the saturating stray-beat counter helper.
package fpga_mem_dmaster_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam int DROP_CNT_W    = 16;
    localparam int NUM_CH_DEF    = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int CHANNEL_W_DEF = 8;

    // At most 8 sources can drop a beat in one cycle, so a 4-bit increment suffices.
    function automatic logic [DROP_CNT_W-1:0] drop_sat_add(
        input logic [DROP_CNT_W-1:0] cnt,
        input logic [3:0]            inc
    );
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(DROP_CNT_W-3){1'b0}}, inc};
        return sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : sum[DROP_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/fpga_mem_dmaster_st_channel_arbiter_if.sv
// Bundle of the NUM_CH Avalon-ST source ports and the merged channelised output.
interface fpga_mem_dmaster_st_channel_arbiter_if
    import fpga_mem_dmaster_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CHANNEL_W = CHANNEL_W_DEF
);
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_startofpacket;
    logic [NUM_CH-1:0]        in_endofpacket;

    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_startofpacket;
    logic                     out_endofpacket;
    logic [CHANNEL_W-1:0]     out_channel;

    modport slave (
        input  in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        output in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_channel
    );

    modport master (
        output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        input  in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_channel
    );
endinterface

// File: rtl/fpga_mem_dmaster_st_channel_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module fpga_mem_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    int j;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        j       = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_CH) begin
                j = j - NUM_CH;
            end
            if (req[IDX_W'(j)]) begin
                gnt_idx = IDX_W'(j);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpga_mem_dmaster_st_channel_arbiter.sv
// Packet-atomic round-robin merge of NUM_CH byte-packet sources onto one
// channelised stream; stray beats seen while idle are swallowed and counted.
module fpga_mem_dmaster_st_channel_arbiter
    import fpga_mem_dmaster_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CHANNEL_W = CHANNEL_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    fpga_mem_dmaster_st_channel_arbiter_if.slave bus,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int IDX_W = $clog2(NUM_CH);

    logic [0:0]            state_reg;
    logic [IDX_W-1:0]      rr_ptr_reg;
    logic [IDX_W-1:0]      grant_reg;
    logic                  out_valid_reg;
    logic                  out_sop_reg;
    logic                  out_eop_reg;
    logic [DATA_W-1:0]     out_data_reg;
    logic [CHANNEL_W-1:0]  out_channel_reg;
    logic [DROP_CNT_W-1:0] drop_count_reg;

    logic [NUM_CH-1:0]     sop_req;
    logic [NUM_CH-1:0]     stray;
    logic [DATA_W-1:0]     src_data [NUM_CH];
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [3:0]            stray_cnt;
    logic                  out_free;
    logic                  accept;
    logic [NUM_CH-1:0]     ready_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_src
            assign sop_req[gi]  = bus.in_valid[gi] & bus.in_startofpacket[gi];
            assign stray[gi]    = bus.in_valid[gi] & ~bus.in_startofpacket[gi];
            assign src_data[gi] = bus.in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    fpga_mem_rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req     (sop_req),
        .ptr     (rr_ptr_reg),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    assign stray_cnt = 4'($countones(stray));
    assign out_free  = ~out_valid_reg | bus.out_ready;
    assign accept    = (state_reg == ST_LOCKED) & bus.in_valid[grant_reg] & out_free;

    // While idle every non-SOP beat is acknowledged so it is dropped, while SOP
    // beats wait for the grant issued this cycle.
    always_comb begin
        ready_vec = '0;
        if (!reset) begin
            if (state_reg == ST_IDLE) begin
                ready_vec = stray;
            end else begin
                ready_vec[grant_reg] = out_free;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            rr_ptr_reg      <= '0;
            grant_reg       <= '0;
            drop_count_reg  <= '0;
            out_valid_reg   <= 1'b0;
            out_sop_reg     <= 1'b0;
            out_eop_reg     <= 1'b0;
            out_data_reg    <= '0;
            out_channel_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE) begin
                drop_count_reg <= drop_sat_add(drop_count_reg, stray_cnt);
                if (pick_any) begin
                    grant_reg <= pick_idx;
                    state_reg <= ST_LOCKED;
                end
            end else if (accept && bus.in_endofpacket[grant_reg]) begin
                state_reg  <= ST_IDLE;
                rr_ptr_reg <= (grant_reg == IDX_W'(NUM_CH - 1)) ? '0 : grant_reg + IDX_W'(1);
            end

            if (accept) begin
                out_valid_reg   <= 1'b1;
                out_data_reg    <= src_data[grant_reg];
                out_sop_reg     <= bus.in_startofpacket[grant_reg];
                out_eop_reg     <= bus.in_endofpacket[grant_reg];
                out_channel_reg <= CHANNEL_W'(grant_reg);
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.in_ready          = ready_vec;
    assign bus.out_valid         = out_valid_reg;
    assign bus.out_data          = out_data_reg;
    assign bus.out_startofpacket = out_sop_reg;
    assign bus.out_endofpacket   = out_eop_reg;
    assign bus.out_channel       = out_channel_reg;
    assign drop_count            = drop_count_reg;

endmodule

// File: doc/fpga_mem_dmaster_st_channel_arbiter.md
# fpga_mem_dmaster_st_channel_arbiter

Packet-atomic round-robin arbiter that merges NUM_CH Avalon-ST byte-packet sources onto the single channelised byte stream feeding the DDR3 EMIF debug master's packet/byte adapter chain. Each output beat carries the winning source index on `out_channel`. A packet, once granted, is never interleaved with another. Stray beats arriving outside a packet are discarded and counted.

## Interface
- `NUM_CH`, 4: number of requesting sources (2..8)
- `DATA_W`, 8: beat width
- `CHANNEL_W`, 8: width of `out_channel`; must be ≥ clog2(NUM_CH)

- `clk` in 1: single clock for all logic
- `reset` in 1: synchronous, active-high reset
- `in_valid` in NUM_CH: per-source valid
- `in_ready` out NUM_CH: per-source ready, ready-latency 0
- `in_data` in NUM_CH*DATA_W: per-source data; source i occupies bits [i*DATA_W +: DATA_W]
- `in_startofpacket` in NUM_CH: per-source SOP
- `in_endofpacket` in NUM_CH: per-source EOP
- `out_valid` out 1: registered output valid
- `out_ready` in 1: downstream ready, ready-latency 0
- `out_data` out DATA_W: registered beat
- `out_startofpacket` out 1: registered SOP
- `out_endofpacket` out 1: registered EOP
- `out_channel` out CHANNEL_W: granted index, zero-extended
- `drop_count` out 16: saturating count of discarded stray beats

## Operation
- States: IDLE, LOCKED.
- IDLE:
  - Candidates: sources with `in_valid & in_startofpacket`.
  - Winner: first candidate at or after `rr_ptr`, searching upward and wrapping.
  - On a winner: register `grant`, go to LOCKED. No beat is accepted in this cycle.
- IDLE stray-beat rule:
  - A source with `in_valid` high and SOP low gets `in_ready` high, so the beat is dropped.
  - `drop_count` increments by the number of such beats in that cycle.
  - `drop_count` saturates at 0xFFFF.
- LOCKED:
  - `in_ready[grant] = !out_valid | out_ready`; all other `in_ready` are 0.
  - An accepted beat loads the output register with data, SOP, EOP and `out_channel = grant`.
  - When a beat with EOP is accepted: go to IDLE and set `rr_ptr = (grant+1) mod NUM_CH`.
- SOP seen mid-packet on the granted source: the beat is forwarded unchanged. The arbiter does not repair framing.
- A single-beat packet (SOP and EOP on the same beat) is legal: LOCKED lasts for that one accepted beat.
- Output register:
  - Holds its contents while `out_valid & !out_ready`.
  - Clears `out_valid` on `out_ready` when no new beat is accepted.
- Reset (also when asserted mid-packet):
  - `state` = IDLE, `rr_ptr` = 0, `grant` = 0, `drop_count` = 0.
  - `out_valid`/SOP/EOP = 0, `out_data` = 0, `out_channel` = 0.
  - `in_ready` = 0 on the reset cycle.
  - A packet in flight is truncated. The downstream re-syncs on its next SOP.

## Timing
- Arbitration: 1 cycle from SOP-valid in IDLE to LOCKED. The first `in_ready` is high in the following cycle.
- Datapath latency: 1 cycle from input accept to `out_valid`.
- Throughput in LOCKED: 1 beat/cycle under continuous `out_ready`.
- Inter-packet gap: exactly 1 bubble cycle (the IDLE arbitration cycle) after each EOP.
- Output signals change only on the clock edge. There are no combinational paths from `in_*` to `out_*`.
- Combinational path from `out_ready` to `in_ready` is permitted.
- Simultaneous events:
  - Multiple SOPs in IDLE: `rr_ptr` decides the winner.
  - A stray beat and an SOP in the same IDLE cycle: the stray beat is dropped and the SOP source is granted.

## Structure
- Package `fpga_mem_dmaster_pkg`: state encoding (IDLE=0, LOCKED=1), `DROP_CNT_W=16`, default width constants.
- Sub-module `fpga_mem_rr_pick`: combinational round-robin picker.
  - Inputs: `req[NUM_CH]`, `ptr`.
  - Outputs: `gnt_idx`, `gnt_any`.
  - Reusable by other debug-path arbiters.
- Top level holds the FSM, output register and drop counter.

## Test plan
- Single source: ch2 sends a 4-beat packet 0x11..0x14 with `out_ready` held high.
  - Expect `out_channel=2` on all beats.
  - Expect SOP on 0x11 and EOP on 0x14.
  - Expect a 1-cycle arbitration gap before the first beat and 1-cycle latency per beat.
- Contention: ch0, ch1 and ch3 all raise SOP together, each sending a 2-beat packet, with `rr_ptr=0`.
  - Expect grant order 0,1,3 with no interleaving.
  - Expect `rr_ptr` ends at 0.
- Backpressure: hold `out_ready` low for 3 cycles mid-packet.
  - `out_data` is stable and `in_ready[grant]` is 0 during the stall.
  - No beat is lost or duplicated.
- Stray beats: ch1 presents 5 valid beats without SOP while IDLE.
  - Expect `drop_count=5` and no `out_valid`.
  - Preset the count to 0xFFFE and drop 3 more: expect 0xFFFF.
- Single-beat packets: ch0 and ch1 send alternating SOP+EOP beats.
  - Expect strict alternation 0,1,0,1, each separated by one bubble cycle.
- Mid-packet reset: assert `reset` on beat 2 of 4.
  - Next cycle: all outputs are 0, `in_ready` is 0, state is IDLE.
  - A subsequent ch3 packet is granted normally.
